// File: rtl/gray_binary.sv
// Registered Gray<->binary converter with a Gray-stream step monitor.
// One word per valid cycle, 1-cycle latency, no backpressure.
module gray_binary #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             step_err
);

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic             vld;
    logic             up;
    logic             dn;
    logic             err;
  } rsp_t;

  rsp_t             rsp_q, rsp_d;
  logic [WIDTH-1:0] prev_g, g_bin, prev_bin, prev_inc, g_gray, diff;
  logic             hist_vld, one_bit, multi_bit;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign g_bin[i]    = ^g[WIDTH-1:i];
    assign prev_bin[i] = ^prev_g[WIDTH-1:i];
  end

  assign g_gray    = g ^ (g >> 1);
  assign prev_inc  = prev_bin + WIDTH'(1);
  assign diff      = g ^ prev_g;
  // Clearing the lowest set bit leaves something only if >1 bit changed.
  assign multi_bit = |(diff & (diff - WIDTH'(1)));
  assign one_bit   = |diff && !multi_bit;

  always_comb begin
    rsp_d     = rsp_q;
    rsp_d.vld = 1'b0;
    rsp_d.up  = 1'b0;
    rsp_d.dn  = 1'b0;
    rsp_d.err = 1'b0;
    if (in_valid) begin
      rsp_d.vld = 1'b1;
      rsp_d.b   = mode ? g_gray : g_bin;
      if (!mode && hist_vld) begin
        rsp_d.err = multi_bit;
        rsp_d.up  = one_bit && (g_bin == prev_inc);
        rsp_d.dn  = one_bit && (g_bin != prev_inc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q    <= '0;
      prev_g   <= '0;
      hist_vld <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
      if (in_valid) begin
        if (mode) begin
          hist_vld <= 1'b0;
        end else begin
          prev_g   <= g;
          hist_vld <= 1'b1;
        end
      end
    end
  end

  assign b         = rsp_q.b;
  assign out_valid = rsp_q.vld;
  assign step_up   = rsp_q.up;
  assign step_dn   = rsp_q.dn;
  assign step_err  = rsp_q.err;

endmodule

// File: tb/tb_gray_binary.sv
// Directed bench for gray_binary: 3-bit instance for the step monitor,
// 8-bit instance for conversion against the XOR reference.
module tb_gray_binary;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, mode;
  logic [2:0] g;
  logic [2:0] b;
  logic       out_valid, step_up, step_dn, step_err;

  logic       in_valid8, mode8;
  logic [7:0] g8, b8;
  logic       out_valid8, step_up8, step_dn8, step_err8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_binary #(.WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .g(g),
    .b(b), .out_valid(out_valid), .step_up(step_up), .step_dn(step_dn),
    .step_err(step_err)
  );

  gray_binary #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .mode(mode8), .g(g8),
    .b(b8), .out_valid(out_valid8), .step_up(step_up8), .step_dn(step_dn8),
    .step_err(step_err8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [2:0] w);
    in_valid = v;
    mode     = m;
    g        = w;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; mode = 1'b0; g = 3'b111;
    tick();
    tick();
    n_checks++;
    if (b !== 3'b000) begin
      n_fail++; $display("FAIL reset_b: got %b want 000", b);
    end
    n_checks++;
    if ({out_valid, step_up, step_dn, step_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {out_valid, step_up, step_dn, step_err});
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
  endtask

  // flags are {step_up, step_dn, step_err}
  task automatic test_sweep();
    logic [2:0] exp_b [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b111, 3'b110, 3'b100, 3'b101};
    logic [2:0] exp_f [8] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b100};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'(i));
      n_checks++;
      if (b !== exp_b[i] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL sweep_b[%0d]: got b=%b v=%b want b=%b v=1", i, b, out_valid, exp_b[i]);
      end
      n_checks++;
      if ({step_up, step_dn, step_err} !== exp_f[i]) begin
        n_fail++; $display("FAIL sweep_flags[%0d]: got %b want %b", i, {step_up, step_dn, step_err}, exp_f[i]);
      end
    end
  endtask

  task automatic test_count_up();
    logic [2:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [2:0] exp_b [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    drive(1'b1, 1'b1, 3'b000);  // binary->Gray word clears history
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, seq[i]);
      n_checks++;
      if (b !== exp_b[i]) begin
        n_fail++; $display("FAIL count_b[%0d]: got %b want %b", i, b, exp_b[i]);
      end
      n_checks++;
      if ({step_up, step_dn, step_err} !== ((i == 0) ? 3'b000 : 3'b100)) begin
        n_fail++; $display("FAIL count_flags[%0d]: got %b want %b", i, {step_up, step_dn, step_err},
                           (i == 0) ? 3'b000 : 3'b100);
      end
    end
  endtask

  task automatic test_count_dn();
    logic [2:0] seq [3]   = '{3'b000, 3'b100, 3'b101};
    logic [2:0] exp_b [3] = '{3'd0, 3'd7, 3'd6};
    logic [2:0] exp_f [3] = '{3'b000, 3'b010, 3'b010};
    drive(1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, seq[i]);
      n_checks++;
      if (b !== exp_b[i] || {step_up, step_dn, step_err} !== exp_f[i]) begin
        n_fail++; $display("FAIL down[%0d]: got b=%b f=%b want b=%b f=%b", i, b,
                           {step_up, step_dn, step_err}, exp_b[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_b2g();
    drive(1'b1, 1'b1, 3'b110);
    n_checks++;
    if (b !== 3'b101 || out_valid !== 1'b1 || {step_up, step_dn, step_err} !== 3'b000) begin
      n_fail++; $display("FAIL b2g_110: got b=%b v=%b f=%b want b=101 v=1 f=000", b, out_valid,
                         {step_up, step_dn, step_err});
    end
    drive(1'b1, 1'b1, 3'b011);
    n_checks++;
    if (b !== 3'b010 || {step_up, step_dn, step_err} !== 3'b000) begin
      n_fail++; $display("FAIL b2g_011: got b=%b f=%b want b=010 f=000", b, {step_up, step_dn, step_err});
    end
    drive(1'b1, 1'b0, 3'b011);
    n_checks++;
    if (b !== 3'b010 || {step_up, step_dn, step_err} !== 3'b000) begin
      n_fail++; $display("FAIL b2g_after: got b=%b f=%b want b=010 f=000", b, {step_up, step_dn, step_err});
    end
  endtask

  task automatic test_gap_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'b111);
      n_checks++;
      if (b !== 3'b010 || {out_valid, step_up, step_dn, step_err} !== 4'b0000) begin
        n_fail++; $display("FAIL gap[%0d]: got b=%b vf=%b want b=010 vf=0000", i, b,
                           {out_valid, step_up, step_dn, step_err});
      end
    end
    // history survives the gap: 011 -> 000 is a two-bit jump
    drive(1'b1, 1'b0, 3'b000);
    n_checks++;
    if (b !== 3'b000 || {step_up, step_dn, step_err} !== 3'b001) begin
      n_fail++; $display("FAIL gap_hist: got b=%b f=%b want b=000 f=001", b, {step_up, step_dn, step_err});
    end
    drive(1'b1, 1'b0, 3'b001);
    n_checks++;
    if ({step_up, step_dn, step_err} !== 3'b100) begin
      n_fail++; $display("FAIL pre_rst_up: got %b want 100", {step_up, step_dn, step_err});
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 3'b011);
    n_checks++;
    if (b !== 3'b000 || {out_valid, step_up, step_dn, step_err} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_rst: got b=%b vf=%b want b=000 vf=0000", b,
                         {out_valid, step_up, step_dn, step_err});
    end
    rst_n = 1'b1;
    // 001 -> 011 would be an up step if history had survived
    drive(1'b1, 1'b0, 3'b011);
    n_checks++;
    if (b !== 3'b010 || {out_valid, step_up, step_dn, step_err} !== 4'b1000) begin
      n_fail++; $display("FAIL post_rst: got b=%b vf=%b want b=010 vf=1000", b,
                         {out_valid, step_up, step_dn, step_err});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wide();
    logic [7:0] w, exp;
    logic       m;
    for (int n = 0; n < 40; n++) begin
      w = 8'($urandom_range(0, 255));
      m = n[0];
      if (m) begin
        exp = w ^ {1'b0, w[7:1]};
      end else begin
        exp[7] = w[7];
        for (int i = 6; i >= 0; i--) exp[i] = exp[i+1] ^ w[i];
      end
      in_valid8 = 1'b1; mode8 = m; g8 = w;
      tick();
      n_checks++;
      if (b8 !== exp || out_valid8 !== 1'b1) begin
        n_fail++; $display("FAIL wide[%0d] mode=%b g=%h: got b=%h v=%b want b=%h v=1", n, m, w, b8,
                           out_valid8, exp);
      end
    end
    in_valid8 = 1'b0;
    tick();
    n_checks++;
    if (out_valid8 !== 1'b0 || b8 !== exp) begin
      n_fail++; $display("FAIL wide_idle: got b=%h v=%b want b=%h v=0", b8, out_valid8, exp);
    end
  endtask

  initial begin
    in_valid8 = 1'b0; mode8 = 1'b0; g8 = '0;
    test_reset();
    test_sweep();
    test_count_up();
    test_count_dn();
    test_b2g();
    test_gap_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
